dense_frame_sequencer: RTL



---
 rtl/dense_frame_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/dense_frame_sequencer.sv
// Transmit side of the dense-layer frame protocol: buffers one activation vector,
// replays it as a framed beat stream, then captures the accumulator result.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | buffer empty, waiting for the first upstream element
// S_LOAD     | filling the buffer, wr_cnt < LEN
// S_READY    | buffer full, waiting for go
// S_START    | frame_start_out pulse; element 0 is fetched here
// S_STREAM   | issuing beats, one per non-stalled cycle
// S_WAIT_RES | waiting for accumulator result, timeout counter running
module dense_frame_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int LEN        = 784,
   parameter int ADDR_WIDTH = 10,
   parameter int TIMEOUT    = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_valid,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic                  load_ready,
   input  logic                  go,
   input  logic                  stall_in,
   output logic                  frame_start_out,
   output logic                  ena_out,
   output logic [DATA_WIDTH-1:0] dense_out,
   output logic                  frame_end_out,
   input  logic                  result_valid_in,
   input  logic [DATA_WIDTH-1:0] result_in,
   output logic                  result_valid_out,
   output logic [DATA_WIDTH-1:0] result_out,
   output logic                  busy,
   output logic                  error
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(LEN - 1);
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_READY,
      S_START,
      S_STREAM,
      S_WAIT_RES
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] mem [0:LEN-1];
   logic [CW-1:0]         wr_cnt;
   logic [CW-1:0]         rd_cnt;
   logic [TW-1:0]         tmo_cnt;
   logic                  wr_en;

   assign wr_en = load_valid & load_ready;

   // Buffer has no reset so it can map onto a RAM; contents are don't-care after rst.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_cnt[ADDR_WIDTH-1:0]] <= load_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= S_IDLE;
         wr_cnt           <= '0;
         rd_cnt           <= '0;
         tmo_cnt          <= '0;
         load_ready       <= 1'b1;
         frame_start_out  <= 1'b0;
         ena_out          <= 1'b0;
         frame_end_out    <= 1'b0;
         dense_out        <= '0;
         result_valid_out <= 1'b0;
         result_out       <= '0;
         busy             <= 1'b0;
         error            <= 1'b0;
      end else begin
         frame_start_out  <= 1'b0;
         ena_out          <= 1'b0;
         frame_end_out    <= 1'b0;
         result_valid_out <= 1'b0;
         case (state)
            S_IDLE, S_LOAD: begin
               if (wr_en) begin
                  wr_cnt <= wr_cnt + 1'b1;
                  if (wr_cnt == LAST_IDX) begin
                     state      <= S_READY;
                     load_ready <= 1'b0;
                  end else begin
                     state <= S_LOAD;
                  end
               end
            end
            S_READY: begin
               if (go) begin
                  state           <= S_START;
                  frame_start_out <= 1'b1;
                  busy            <= 1'b1;
                  error           <= 1'b0;
                  rd_cnt          <= '0;
               end
            end
            S_START: begin
               // Element 0 is fetched unconditionally so it lands the cycle after the start pulse.
               ena_out   <= 1'b1;
               dense_out <= mem[rd_cnt[ADDR_WIDTH-1:0]];
               rd_cnt    <= rd_cnt + 1'b1;
               state     <= S_STREAM;
            end
            S_STREAM: begin
               if (!stall_in) begin
                  ena_out   <= 1'b1;
                  dense_out <= mem[rd_cnt[ADDR_WIDTH-1:0]];
                  rd_cnt    <= rd_cnt + 1'b1;
                  if (rd_cnt == LAST_IDX) begin
                     frame_end_out <= 1'b1;
                     state         <= S_WAIT_RES;
                     tmo_cnt       <= TMO_LOAD;
                  end
               end
            end
            S_WAIT_RES: begin
               if (result_valid_in) begin
                  result_out       <= result_in;
                  result_valid_out <= 1'b1;
                  wr_cnt           <= '0;
                  state            <= S_IDLE;
                  load_ready       <= 1'b1;
                  busy             <= 1'b0;
               end else if (tmo_cnt == '0) begin
                  error      <= 1'b1;
                  wr_cnt     <= '0;
                  state      <= S_IDLE;
                  load_ready <= 1'b1;
                  busy       <= 1'b0;
               end else begin
                  tmo_cnt <= tmo_cnt - 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
